// File: rtl/pipelined_subtractor_if.sv
// pipelined_subtractor_if
//   Operand/result handshake bundle for pipelined_subtractor.
//   Ports (through the modports):
//     in_valid / in_ready   operand transfer handshake
//     a, b                  minuend and subtrahend, K bits
//     out_valid / out_ready result transfer handshake
//     diff                  a - b mod 2^K
//     borrow                1 iff a < b unsigned
//     overflow              signed overflow of a - b
//   master: the side that supplies operands and consumes results.
//   slave:  the subtractor itself.
interface pipelined_subtractor_if #(
  parameter int K = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] a;
  logic [K-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [K-1:0] diff;
  logic         borrow;
  logic         overflow;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, overflow
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, overflow
  );
endinterface

// File: rtl/pipelined_subtractor.sv
// pipelined_subtractor
//   Two-stage pipelined K-bit subtractor, diff = a - b, built as
//   a + ~b + 1 with borrow-select on the upper half. Stage 1 forms the low
//   half and both upper-half candidates (carry-in 0 and 1); stage 2 picks the
//   upper candidate with the registered low-half carry. Full valid/ready
//   backpressure, one operation per cycle, two operations in flight at most.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset; drops everything in flight
//     bus   pipelined_subtractor_if.slave (operands in, results out)
//   K must be even and >= 2.
module pipelined_subtractor #(
  parameter int K = 16
) (
  input logic                   clk,
  input logic                   rst,
  pipelined_subtractor_if.slave bus
);
  localparam int H = K / 2;

  // stage 1 registers
  logic         s1_valid;
  logic [H-1:0] diff_lo_q;
  logic         c_lo_q;
  logic [H-1:0] s0_q;
  logic         c0_q;
  logic [H-1:0] s1_q;
  logic         c1_q;
  logic         a_msb_q;
  logic         b_msb_q;

  // stage 2 (output) registers
  logic         out_valid_q;
  logic [K-1:0] diff_q;
  logic         borrow_q;
  logic         overflow_q;

  // combinational stage results
  logic [H:0]   lo_sum;
  logic [H:0]   hi0_sum;
  logic [H:0]   hi1_sum;
  logic [H-1:0] hi_sel;
  logic         c_sel;
  logic         overflow_nxt;

  logic         s2_adv;
  logic         accept;

  // in_ready depends only on registered state, out_ready and rst, so a
  // producer may safely derive in_valid from it without a loop.
  assign s2_adv       = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !rst && (!s1_valid || s2_adv);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    lo_sum  = {1'b0, bus.a[H-1:0]} + {1'b0, ~bus.b[H-1:0]} + {{H{1'b0}}, 1'b1};
    hi0_sum = {1'b0, bus.a[K-1:H]} + {1'b0, ~bus.b[K-1:H]};
    hi1_sum = {1'b0, bus.a[K-1:H]} + {1'b0, ~bus.b[K-1:H]} + {{H{1'b0}}, 1'b1};
  end

  // A carry out of the low half means no low-half borrow, so the upper half
  // takes the candidate that was computed with carry-in 1.
  always_comb begin
    hi_sel       = c_lo_q ? s1_q : s0_q;
    c_sel        = c_lo_q ? c1_q : c0_q;
    overflow_nxt = (a_msb_q != b_msb_q) && (hi_sel[H-1] != a_msb_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      diff_lo_q   <= '0;
      c_lo_q      <= 1'b0;
      s0_q        <= '0;
      c0_q        <= 1'b0;
      s1_q        <= '0;
      c1_q        <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (s2_adv) begin
        out_valid_q <= s1_valid;
        if (s1_valid) begin
          diff_q     <= {hi_sel, diff_lo_q};
          borrow_q   <= ~c_sel;
          overflow_q <= overflow_nxt;
        end
      end

      if (accept) begin
        s1_valid  <= 1'b1;
        diff_lo_q <= lo_sum[H-1:0];
        c_lo_q    <= lo_sum[H];
        s0_q      <= hi0_sum[H-1:0];
        c0_q      <= hi0_sum[H];
        s1_q      <= hi1_sum[H-1:0];
        c1_q      <= hi1_sum[H];
        a_msb_q   <= bus.a[K-1];
        b_msb_q   <= bus.b[K-1];
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.overflow  = overflow_q;
endmodule
